// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier built around one 16-bit skip-carry adder.
// Latency 16 clocks from accept to out_valid; result holds in DONE while out_ready is low.

module skip_carry_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  always_comb begin
    logic [15:0] p;
    logic [15:0] g;
    logic [4:0]  bc;
    logic        c;
    p   = a ^ b;
    g   = a & b;
    bc  = '0;
    c   = cin;
    sum = '0;
    bc[0] = cin;
    for (int k = 0; k < 4; k++) begin
      c = bc[k];
      for (int i = 0; i < 4; i++) begin
        sum[4*k+i] = p[4*k+i] ^ c;
        c          = g[4*k+i] | (p[4*k+i] & c);
      end
      // A fully propagating block forwards its carry-in straight past the ripple chain.
      bc[k+1] = (&p[4*k +: 4]) ? bc[k] : c;
    end
    cout = bc[4];
  end

endmodule

module seq_shift_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  if (WIDTH != 16) begin : g_bad_width
    $error("seq_shift_add_multiplier: WIDTH must be 16");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [4:0]       count;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             last_iter;

  assign add_b     = acc_lo[0] ? mcand : '0;
  assign last_iter = (count == 5'(WIDTH - 1));

  skip_carry_adder u_adder (
    .a    (acc_hi),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mcand  <= a;
          acc_hi <= '0;
          acc_lo <= b;
          count  <= '0;
        end
        // Carry-out lands in acc_hi MSB so the full 2*WIDTH product is kept.
        RUN: begin
          {acc_hi, acc_lo} <= {add_cout, add_sum, acc_lo[WIDTH-1:1]};
          count            <= count + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign product = {acc_hi, acc_lo};

endmodule

// File: doc/seq_shift_add_multiplier.md
# seq_shift_add_multiplier

Sequential unsigned shift-and-add multiplier that uses one `skip_carry_adder` as its only arithmetic element, one partial-product addition per clock. It sits directly downstream of the adder library. It registers operands through a valid/ready input handshake, iterates WIDTH cycles, and holds the double-width product on a valid/ready output handshake. It is the first clocked consumer of the skip carry adder and the template for later sequential multipliers.

## Interface
- `WIDTH`, 16: operand width. Only 16 is legal because the adder ports are fixed at 16 bits. Any other value fails elaboration.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `in_valid`  input  1  operands `a`/`b` are valid.
- `in_ready`  output  1  block can accept operands; equals (state == IDLE).
- `a`  input  WIDTH  multiplicand, unsigned.
- `b`  input  WIDTH  multiplier, unsigned.
- `out_valid`  output  1  `product` is valid; equals (state == DONE).
- `out_ready`  input  1  downstream accepts `product`.
- `product`  output  2*WIDTH  unsigned a*b, registered.

## Operation
- Registers:
  - `mcand[WIDTH-1:0]`
  - `acc_hi[WIDTH-1:0]`
  - `acc_lo[WIDTH-1:0]`
  - `count[4:0]`
  - `state`
- `product` = {acc_hi, acc_lo}.
- States:
  - IDLE: if in_valid, this is an accept edge. Set mcand←a, acc_hi←0, acc_lo←b, count←0, and go to RUN. Otherwise stay in IDLE.
  - RUN: on each edge, with the adder driven by `a=acc_hi`, `b=(acc_lo[0] ? mcand : 0)`, `cin=0` (giving sum, cout):
    - {acc_hi, acc_lo} ← {cout, sum, acc_lo[WIDTH-1:1]}, a 2*WIDTH+1-bit value right-shifted by one.
    - count←count+1.
    - When count == WIDTH-1 on that edge, go to DONE.
  - DONE: hold all registers. If out_ready, go to IDLE. Otherwise stay in DONE.
- Arithmetic:
  - The carry out of the adder is never dropped; it becomes acc_hi[WIDTH-1] after the shift.
  - The final product is exact over the full 32-bit range. The maximum is 0xFFFF*0xFFFF = 0xFFFE0001.
- Zero multiplier: still runs all WIDTH iterations (no early exit) and produces 0.
- Inputs outside IDLE:
  - in_valid and a/b are ignored in RUN and DONE. in_ready is 0 in those states.
  - out_ready is ignored outside DONE.
- Reset:
  - While rst_n is low: state=IDLE, all data registers and count = 0.
  - Therefore in_ready=1, out_valid=0, product=0.
  - Reset mid-RUN or in DONE discards the operation immediately; no output handshake occurs.
- Simultaneous events:
  - The DONE→IDLE transfer edge cannot also accept new operands; acceptance happens on a later edge from IDLE.
  - product keeps the last result in IDLE until the next accept edge, where acc_hi is cleared. product is only meaningful while out_valid=1.

## Timing
- Accept edge E0 (IDLE, in_valid=1). The RUN iterations occur on edges E1..E16.
- out_valid rises after E16, i.e. 16 clocks after the accept edge.
- product is stable and correct for every cycle out_valid=1. While out_ready=0, product and out_valid must not change.
- Output transfer on the edge with out_valid && out_ready. out_valid falls and in_ready rises in the following cycle.
- Minimum initiation interval, with in_valid and out_ready tied high, is 18 clocks per operation: 1 IDLE + 16 RUN + 1 DONE.
- The combinational path per cycle is one 16-bit skip-carry add plus the mux on its b input. No other arithmetic is in the loop.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release. Required: in_ready=1, out_valid=0, product=0x00000000. Assert rst_n asynchronously mid-cycle: outputs clear without waiting for a clock edge.
- Full-range operands: a=0xFFFF, b=0xFFFF, out_ready=1. Required: out_valid exactly 16 clocks after the accept edge, product=0xFFFE0001, in_ready back to 1 one cycle after the transfer.
- Identity and zero cases:
  - 0x1234*0x0000 → 0x00000000.
  - 0x0001*0xABCD → 0x0000ABCD.
  - 0x8000*0x0002 → 0x00010000.
  - Each must take 16 RUN cycles.
- Backpressure: 0x00FF*0x0101 with out_ready=0 for 5 cycles after out_valid rises. Required: product stays 0x0000FFFF and out_valid stays 1 throughout. A new in_valid with a=0x1111 during RUN/DONE is ignored (in_ready=0).
- Reset mid-operation: drop rst_n at RUN cycle 7 of 0x1234*0x5678. Required: IDLE, out_valid=0, and no output transfer. The next operation 0x0003*0x0005 must yield 0x0000000F.
- Random stream: 1000 random operand pairs with random in_valid/out_ready stalls, checked against a scoreboard computing a*b. Required: no mismatches, no lost or duplicated results, and exactly 18 clocks per operation when both handshakes are held high.
